// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter from two CPU line-miss ports onto one shared d_mem port
// Serialises line reads/writes, routes each response to its requester and flags hung d_mem accesses.
module dmem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu0_u_addr,
  input  logic              cpu0_u_re,
  input  logic              cpu0_u_we,
  input  logic [LINE_W-1:0] cpu0_d_line,
  output logic [LINE_W-1:0] cpu0_u_rd_data,
  output logic              cpu0_u_rdy,
  input  logic [ADDR_W-1:0] cpu1_u_addr,
  input  logic              cpu1_u_re,
  input  logic              cpu1_u_we,
  input  logic [LINE_W-1:0] cpu1_d_line,
  output logic [LINE_W-1:0] cpu1_u_rd_data,
  output logic              cpu1_u_rdy,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [LINE_W-1:0] dmem_wdata,
  input  logic [LINE_W-1:0] dmem_rd_data,
  input  logic              dmem_rdy,
  output logic [1:0]        owner,
  output logic              timeout_err
);

  // The timer never needs to count past TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q;
  logic              last_q;
  logic [TW-1:0]     timer_q;
  logic [ADDR_W-1:0] addr_q;
  logic              re_q, we_q;
  logic [LINE_W-1:0] wdata_q;
  logic [1:0]        owner_q;
  logic [LINE_W-1:0] rd0_q, rd1_q;
  logic              rdy0_q, rdy1_q;
  logic              terr_q;

  logic              req0, req1, pick1_d, g_we, expire;
  logic [ADDR_W-1:0] g_addr;
  logic [LINE_W-1:0] g_line;

  always_comb begin
    req0    = cpu0_u_re | cpu0_u_we;
    req1    = cpu1_u_re | cpu1_u_we;
    // last_q=1 means CPU1 won the previous tie, so CPU0 takes the next one.
    pick1_d = req1 & (~req0 | ~last_q);
    g_addr  = pick1_d ? cpu1_u_addr : cpu0_u_addr;
    g_we    = pick1_d ? cpu1_u_we   : cpu0_u_we;
    g_line  = pick1_d ? cpu1_d_line : cpu0_d_line;
    expire  = (TIMEOUT != 0) && (timer_q == TLAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      timer_q <= '0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      owner_q <= 2'b00;
      rd0_q   <= '0;
      rd1_q   <= '0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      rdy0_q <= 1'b0;
      rdy1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            owner_q <= pick1_d ? 2'b10 : 2'b01;
            addr_q  <= g_addr;
            we_q    <= g_we;
            re_q    <= ~g_we;
            wdata_q <= g_line;
            timer_q <= '0;
            if (req0 & req1) last_q <= pick1_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // A response arriving on the expiry cycle still completes normally.
          if (dmem_rdy || expire) begin
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            rdy0_q  <= owner_q[0];
            rdy1_q  <= owner_q[1];
            state_q <= RESP;
            if (!dmem_rdy) begin
              terr_q <= 1'b1;
            end else if (re_q) begin
              if (owner_q[1]) rd1_q <= dmem_rd_data;
              else            rd0_q <= dmem_rd_data;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: begin
          owner_q <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_addr      = addr_q;
  assign dmem_re        = re_q;
  assign dmem_we        = we_q;
  assign dmem_wdata     = wdata_q;
  assign owner          = owner_q;
  assign cpu0_u_rd_data = rd0_q;
  assign cpu1_u_rd_data = rd1_q;
  assign cpu0_u_rdy     = rdy0_q;
  assign cpu1_u_rdy     = rdy1_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Transaction-level reference: round-robin order, write-wins, response routing and timeout rules.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int LW = 64;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [AW-1:0] cpu0_u_addr = '0, cpu1_u_addr = '0;
  logic cpu0_u_re = 1'b0, cpu0_u_we = 1'b0, cpu1_u_re = 1'b0, cpu1_u_we = 1'b0;
  logic [LW-1:0] cpu0_d_line = '0, cpu1_d_line = '0;
  logic [LW-1:0] cpu0_u_rd_data, cpu1_u_rd_data;
  logic cpu0_u_rdy, cpu1_u_rdy;
  logic [AW-1:0] dmem_addr;
  logic dmem_re, dmem_we;
  logic [LW-1:0] dmem_wdata;
  logic [LW-1:0] dmem_rd_data = '0;
  logic dmem_rdy = 1'b0;
  logic [1:0] owner;
  logic timeout_err;

  dmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu0_u_addr(cpu0_u_addr), .cpu0_u_re(cpu0_u_re), .cpu0_u_we(cpu0_u_we),
    .cpu0_d_line(cpu0_d_line), .cpu0_u_rd_data(cpu0_u_rd_data), .cpu0_u_rdy(cpu0_u_rdy),
    .cpu1_u_addr(cpu1_u_addr), .cpu1_u_re(cpu1_u_re), .cpu1_u_we(cpu1_u_we),
    .cpu1_d_line(cpu1_d_line), .cpu1_u_rd_data(cpu1_u_rd_data), .cpu1_u_rdy(cpu1_u_rdy),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rd_data(dmem_rd_data), .dmem_rdy(dmem_rdy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [LW-1:0] exp_rd0 = '0, exp_rd1 = '0;
  int   model_last = 1;
  logic exp_terr = 1'b0;

  // Observations of the most recent transaction
  int o_delay, o_held, o_cnt0, o_cnt1;
  logic [AW-1:0] o_addr;
  logic o_we, o_re, o_stable, o_rdy_now;
  logic [LW-1:0] o_wdata;
  logic [1:0] o_owner, o_owner_resp, o_owner_after;

  task automatic set_req(input int cpu, input logic re, input logic we,
                         input logic [AW-1:0] addr, input logic [LW-1:0] line);
    if (cpu == 0) begin
      cpu0_u_re = re; cpu0_u_we = we; cpu0_u_addr = addr; cpu0_d_line = line;
    end else begin
      cpu1_u_re = re; cpu1_u_we = we; cpu1_u_addr = addr; cpu1_d_line = line;
    end
  endtask

  // Plays d_mem for one transaction; lat=0 means d_mem never answers.
  task automatic do_txn(input int lat, input logic [LW-1:0] rdata);
    o_delay = 0; o_held = 0; o_cnt0 = 0; o_cnt1 = 0; o_stable = 1'b1; o_rdy_now = 1'b0;
    o_owner = 2'b00; o_owner_resp = 2'b00; o_owner_after = 2'b11;
    o_addr = '0; o_we = 1'b0; o_re = 1'b0; o_wdata = '0;
    while (o_delay < 20) begin
      @(posedge clk); @(negedge clk); o_delay++;
      o_cnt0 += int'(cpu0_u_rdy); o_cnt1 += int'(cpu1_u_rdy);
      if (dmem_re | dmem_we) break;
    end
    if (!(dmem_re | dmem_we)) return;
    o_addr = dmem_addr; o_we = dmem_we; o_re = dmem_re; o_wdata = dmem_wdata; o_owner = owner;
    o_held = 1;
    for (int i = 0; i < 40; i++) begin
      if (lat != 0 && o_held == lat) begin dmem_rdy = 1'b1; dmem_rd_data = rdata; end
      @(posedge clk); @(negedge clk);
      dmem_rdy = 1'b0;
      o_cnt0 += int'(cpu0_u_rdy); o_cnt1 += int'(cpu1_u_rdy);
      if (!(dmem_re | dmem_we)) break;
      o_held++;
      if (dmem_addr !== o_addr || dmem_we !== o_we || dmem_re !== o_re ||
          dmem_wdata !== o_wdata || owner !== o_owner) o_stable = 1'b0;
    end
    o_rdy_now = o_owner[1] ? cpu1_u_rdy : cpu0_u_rdy;
    o_owner_resp = owner;
    @(posedge clk); @(negedge clk);
    o_cnt0 += int'(cpu0_u_rdy); o_cnt1 += int'(cpu1_u_rdy);
    o_owner_after = owner;
    if (o_owner[0]) begin cpu0_u_re = 1'b0; cpu0_u_we = 1'b0; end
    if (o_owner[1]) begin cpu1_u_re = 1'b0; cpu1_u_we = 1'b0; end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if ({dmem_re, dmem_we, dmem_addr, dmem_wdata} !== '0) begin errors++; $display("FAIL reset_dmem got re=%b we=%b addr=%h wdata=%h want all 0", dmem_re, dmem_we, dmem_addr, dmem_wdata); end
    checks++; if ({owner, cpu0_u_rdy, cpu1_u_rdy, timeout_err} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got owner=%b rdy0=%b rdy1=%b terr=%b want 0", owner, cpu0_u_rdy, cpu1_u_rdy, timeout_err); end
    checks++; if ({cpu0_u_rd_data, cpu1_u_rd_data} !== '0) begin errors++; $display("FAIL reset_rd got %h %h want 0", cpu0_u_rd_data, cpu1_u_rd_data); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 1'b0, 16'h0040, '0);
    do_txn(3, 64'h1111_2222_3333_4444);
    exp_rd0 = 64'h1111_2222_3333_4444;
    checks++; if (o_delay !== 1) begin errors++; $display("FAIL rd_grant_latency got %0d want 1", o_delay); end
    checks++; if ({o_re, o_we, o_owner, o_addr} !== {2'b10, 2'b01, 16'h0040}) begin errors++; $display("FAIL rd_issue got re=%b we=%b owner=%b addr=%h want 1 0 01 0040", o_re, o_we, o_owner, o_addr); end
    checks++; if (o_held !== 3 || !o_stable) begin errors++; $display("FAIL rd_hold got held=%0d stable=%b want 3 1", o_held, o_stable); end
    checks++; if (o_rdy_now !== 1'b1 || o_cnt0 !== 1 || o_cnt1 !== 0) begin errors++; $display("FAIL rd_rdy got now=%b cnt0=%0d cnt1=%0d want 1 1 0", o_rdy_now, o_cnt0, o_cnt1); end
    checks++; if (cpu0_u_rd_data !== exp_rd0 || cpu1_u_rd_data !== exp_rd1) begin errors++; $display("FAIL rd_data got %h %h want %h %h", cpu0_u_rd_data, cpu1_u_rd_data, exp_rd0, exp_rd1); end
    checks++; if (o_owner_resp !== 2'b01 || o_owner_after !== 2'b00) begin errors++; $display("FAIL rd_owner_clear got resp=%b after=%b want 01 00", o_owner_resp, o_owner_after); end
  endtask

  task automatic test_round_robin();
    logic [1:0] seen [4];
    set_req(0, 1'b0, 1'b1, 16'h0A00, 64'h0123_4567_89AB_CDEF);
    set_req(1, 1'b1, 1'b0, 16'h0B00, '0);
    do_txn(2, 64'h5555_6666_7777_8888); seen[0] = o_owner;
    checks++; if (o_we !== 1'b1 || o_addr !== 16'h0A00 || o_cnt1 !== 0) begin errors++; $display("FAIL rr_first_op got we=%b addr=%h cnt1=%0d want 1 0a00 0", o_we, o_addr, o_cnt1); end
    do_txn(2, 64'h9999_AAAA_BBBB_CCCC); seen[1] = o_owner;
    exp_rd1 = 64'h9999_AAAA_BBBB_CCCC;
    checks++; if (cpu1_u_rd_data !== exp_rd1 || cpu0_u_rd_data !== exp_rd0) begin errors++; $display("FAIL rr_rd_route got %h %h want %h %h", cpu0_u_rd_data, cpu1_u_rd_data, exp_rd0, exp_rd1); end
    set_req(0, 1'b1, 1'b0, 16'h0C00, '0);
    set_req(1, 1'b1, 1'b0, 16'h0D00, '0);
    do_txn(1, 64'h0); seen[2] = o_owner;
    if (o_owner[1]) exp_rd1 = 64'h0; else exp_rd0 = 64'h0;
    do_txn(1, 64'h1); seen[3] = o_owner;
    if (o_owner[1]) exp_rd1 = 64'h1; else exp_rd0 = 64'h1;
    model_last = 1;
    checks++; if ({seen[0], seen[1], seen[2], seen[3]} !== 8'b01_10_10_01) begin errors++; $display("FAIL rr_order got %b %b %b %b want 01 10 10 01", seen[0], seen[1], seen[2], seen[3]); end
  endtask

  task automatic test_write();
    set_req(1, 1'b0, 1'b1, 16'h0100, 64'hDEAD_BEEF_CAFE_F00D);
    do_txn(4, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if ({o_we, o_re, o_owner, o_addr} !== {2'b10, 2'b10, 16'h0100}) begin errors++; $display("FAIL wr_issue got we=%b re=%b owner=%b addr=%h want 1 0 10 0100", o_we, o_re, o_owner, o_addr); end
    checks++; if (o_wdata !== 64'hDEAD_BEEF_CAFE_F00D || o_held !== 4 || !o_stable) begin errors++; $display("FAIL wr_data_hold got wdata=%h held=%0d stable=%b want deadbeefcafef00d 4 1", o_wdata, o_held, o_stable); end
    checks++; if (o_cnt1 !== 1 || o_cnt0 !== 0 || cpu1_u_rd_data !== exp_rd1) begin errors++; $display("FAIL wr_resp got cnt1=%0d cnt0=%0d rd1=%h want 1 0 %h", o_cnt1, o_cnt0, cpu1_u_rd_data, exp_rd1); end
  endtask

  task automatic test_rdy_at_expiry();
    set_req(0, 1'b1, 1'b0, 16'h0777, '0);
    do_txn(TO, 64'hABCD_0000_1234_5678);
    exp_rd0 = 64'hABCD_0000_1234_5678;
    checks++; if (o_held !== TO || timeout_err !== 1'b0) begin errors++; $display("FAIL expiry_rdy_wins got held=%0d terr=%b want %0d 0", o_held, timeout_err, TO); end
    checks++; if (cpu0_u_rd_data !== exp_rd0 || o_cnt0 !== 1) begin errors++; $display("FAIL expiry_data got rd0=%h cnt0=%0d want %h 1", cpu0_u_rd_data, o_cnt0, exp_rd0); end
  endtask

  task automatic test_rdy_outside_busy();
    int rdys;
    rdys = 0;
    dmem_rdy = 1'b1; dmem_rd_data = 64'h0BAD_0BAD_0BAD_0BAD;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      rdys += int'(cpu0_u_rdy) + int'(cpu1_u_rdy) + int'(owner != 2'b00) + int'(dmem_re | dmem_we);
    end
    dmem_rdy = 1'b0;
    checks++; if (rdys !== 0 || cpu0_u_rd_data !== exp_rd0 || cpu1_u_rd_data !== exp_rd1) begin errors++; $display("FAIL idle_rdy_ignored got activity=%0d rd0=%h rd1=%h want 0 %h %h", rdys, cpu0_u_rd_data, cpu1_u_rd_data, exp_rd0, exp_rd1); end
  endtask

  task automatic test_timeout();
    set_req(1, 1'b1, 1'b0, 16'h0200, '0);
    do_txn(0, '0);
    exp_terr = 1'b1;
    checks++; if (o_held !== TO || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_abort got held=%0d terr=%b want %0d 1", o_held, timeout_err, TO); end
    checks++; if (o_rdy_now !== 1'b1 || o_cnt1 !== 1 || o_cnt0 !== 0 || cpu1_u_rd_data !== exp_rd1) begin errors++; $display("FAIL timeout_resp got now=%b cnt1=%0d cnt0=%0d rd1=%h want 1 1 0 %h", o_rdy_now, o_cnt1, o_cnt0, cpu1_u_rd_data, exp_rd1); end
    set_req(0, 1'b0, 1'b1, 16'h0300, 64'h1357_9BDF_2468_ACE0);
    do_txn(2, '0);
    checks++; if (o_owner !== 2'b01 || o_held !== 2 || o_cnt0 !== 1 || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_recover got owner=%b held=%0d cnt0=%0d terr=%b want 01 2 1 1", o_owner, o_held, o_cnt0, timeout_err); end
  endtask

  task automatic test_random();
    logic [AW-1:0] addr [2];
    logic [LW-1:0] line [2];
    logic          wr   [2];
    int order [2];
    int n, mask, c, lat;
    logic [LW-1:0] rdata;
    for (int it = 0; it < 30; it++) begin
      mask = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++) begin
        logic re, we;
        addr[k] = AW'($urandom); line[k] = {$urandom, $urandom};
        re = 1'($urandom); we = 1'($urandom);
        if (!re && !we) re = 1'b1;
        wr[k] = we;
        if (mask[k]) set_req(k, re, we, addr[k], line[k]);
      end
      if (mask == 3) begin
        order[0] = (model_last == 1) ? 0 : 1; order[1] = 1 - order[0];
        model_last = order[0]; n = 2;
      end else begin
        order[0] = (mask == 2) ? 1 : 0; order[1] = 0; n = 1;
      end
      for (int j = 0; j < n; j++) begin
        c = order[j];
        lat = $urandom_range(1, TO);
        rdata = {$urandom, $urandom};
        do_txn(lat, rdata);
        if (!wr[c]) begin if (c == 1) exp_rd1 = rdata; else exp_rd0 = rdata; end
        checks++; if (o_delay !== 1 || o_owner !== 2'(1 << c)) begin errors++; $display("FAIL rnd_grant it=%0d got delay=%0d owner=%b want 1 %b", it, o_delay, o_owner, 2'(1 << c)); end
        checks++; if (o_addr !== addr[c] || o_we !== wr[c] || o_re !== !wr[c] || (wr[c] && o_wdata !== line[c])) begin errors++; $display("FAIL rnd_issue it=%0d got addr=%h we=%b re=%b wdata=%h want %h %b %b %h", it, o_addr, o_we, o_re, o_wdata, addr[c], wr[c], !wr[c], line[c]); end
        checks++; if (o_held !== lat || !o_stable || o_owner_after !== 2'b00) begin errors++; $display("FAIL rnd_hold it=%0d got held=%0d stable=%b after=%b want %0d 1 00", it, o_held, o_stable, o_owner_after, lat); end
        checks++; if (o_cnt0 !== int'(c == 0) || o_cnt1 !== int'(c == 1) || o_rdy_now !== 1'b1) begin errors++; $display("FAIL rnd_rdy it=%0d got cnt0=%0d cnt1=%0d now=%b want %0d %0d 1", it, o_cnt0, o_cnt1, o_rdy_now, int'(c == 0), int'(c == 1)); end
        checks++; if (cpu0_u_rd_data !== exp_rd0 || cpu1_u_rd_data !== exp_rd1 || timeout_err !== exp_terr) begin errors++; $display("FAIL rnd_state it=%0d got rd0=%h rd1=%h terr=%b want %h %h %b", it, cpu0_u_rd_data, cpu1_u_rd_data, timeout_err, exp_rd0, exp_rd1, exp_terr); end
      end
      cpu0_u_re = 1'b0; cpu0_u_we = 1'b0; cpu1_u_re = 1'b0; cpu1_u_we = 1'b0;
    end
  endtask

  task automatic test_write_wins_and_reset();
    int rdys;
    rdys = 0;
    set_req(0, 1'b1, 1'b1, 16'h0ABC, 64'h0F0F_0F0F_F0F0_F0F0);
    @(posedge clk); @(negedge clk);
    checks++; if ({dmem_we, dmem_re} !== 2'b10 || dmem_addr !== 16'h0ABC || dmem_wdata !== 64'h0F0F_0F0F_F0F0_F0F0) begin errors++; $display("FAIL both_write_wins got we=%b re=%b addr=%h wdata=%h want 1 0 0abc 0f0f0f0ff0f0f0f0", dmem_we, dmem_re, dmem_addr, dmem_wdata); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++; if ({dmem_re, dmem_we, owner, cpu0_u_rdy, cpu1_u_rdy, timeout_err} !== 7'b0 || {dmem_addr, dmem_wdata, cpu0_u_rd_data, cpu1_u_rd_data} !== '0) begin errors++; $display("FAIL midbusy_reset got re=%b we=%b owner=%b rdy=%b%b terr=%b want all 0", dmem_re, dmem_we, owner, cpu0_u_rdy, cpu1_u_rdy, timeout_err); end
    cpu0_u_re = 1'b0; cpu0_u_we = 1'b0;
    dmem_rdy = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); rdys += int'(cpu0_u_rdy) + int'(cpu1_u_rdy) + int'(owner != 2'b00); end
    dmem_rdy = 1'b0;
    checks++; if (rdys !== 0) begin errors++; $display("FAIL post_reset_quiet got activity=%0d want 0", rdys); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_rdy_at_expiry();
    test_rdy_outside_busy();
    test_timeout();
    test_random();
    test_write_wins_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
